// File: rtl/acc_pkg.sv
// Shared accelerator queue definitions: word width, fetcher FSM states and the
// slot word order used by both the queue writer and the task fetcher.
package acc_pkg;

  localparam int WORD_W = 64;

  // Position of each field inside a ready-queue slot.
  localparam int SLOT_TID_IDX  = 0;
  localparam int SLOT_TWID_IDX = 1;
  localparam int SLOT_ARG0_IDX = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LAST,
    VALID
  } fetch_state_e;

endpackage

// File: rtl/queue_read_if.sv
// Read-side port of the ready queue: dout is registered by the queue and
// appears one cycle after read.
interface QueueRead;
  import acc_pkg::*;

  logic              read;
  logic              empty;
  logic [WORD_W-1:0] dout;

  modport master (output read, input empty, input dout);
  modport slave  (input read, output empty, output dout);

endinterface

// File: rtl/acc_task_fetcher.sv
// Pops one complete task slot from the ready queue, assembles the task
// descriptor and offers it to the accelerator core over valid/ready.
module acc_task_fetcher
  import acc_pkg::*;
#(
  parameter int NARGS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  QueueRead.master                read_port,
  output logic                    task_valid,
  input  logic                    task_ready,
  output logic [WORD_W-1:0]       task_id,
  output logic [WORD_W-1:0]       task_wid,
  output logic [WORD_W*NARGS-1:0] task_args,
  output logic [31:0]             tasks_dispatched
);

  localparam int SLOT_SIZE = NARGS + 2;
  localparam int CNT_W     = $clog2(SLOT_SIZE + 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  cap_cnt_q;
  logic [31:0]       disp_cnt_q;
  logic [WORD_W-1:0] payload_q [SLOT_SIZE];
  logic              capture;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!read_port.empty) state_d = READ;
      READ:  if (rd_cnt_q == CNT_W'(SLOT_SIZE - 1)) state_d = LAST;
      LAST:  state_d = VALID;
      VALID: if (task_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dout lags read by one cycle, so the word is captured the cycle after its read.
  assign capture        = ((state_q == READ) && (rd_cnt_q != '0)) || (state_q == LAST);
  assign read_port.read = (state_q == READ);
  assign task_valid     = (state_q == VALID);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      cap_cnt_q  <= '0;
      disp_cnt_q <= '0;
      // NOTE: the payload is a handful of flops driving outputs with defined
      // reset values, so unlike a RAM it is reset explicitly.
      for (int i = 0; i < SLOT_SIZE; i++) payload_q[i] <= '0;
    end else begin
      state_q <= state_d;

      if ((state_q == IDLE) && !read_port.empty) begin
        rd_cnt_q  <= '0;
        cap_cnt_q <= '0;
      end

      if (state_q == READ) rd_cnt_q <= rd_cnt_q + CNT_W'(1);

      if (capture) begin
        cap_cnt_q <= cap_cnt_q + CNT_W'(1);
        for (int i = 0; i < SLOT_SIZE; i++) begin
          if (cap_cnt_q == CNT_W'(i)) payload_q[i] <= read_port.dout;
        end
      end

      if ((state_q == VALID) && task_ready) disp_cnt_q <= disp_cnt_q + 32'd1;
    end
  end

  assign task_id          = payload_q[SLOT_TID_IDX];
  assign task_wid         = payload_q[SLOT_TWID_IDX];
  assign tasks_dispatched = disp_cnt_q;

  always_comb begin
    task_args = '0;
    for (int i = 0; i < NARGS; i++) begin
      task_args[WORD_W*i +: WORD_W] = payload_q[SLOT_ARG0_IDX + i];
    end
  end

endmodule

// File: doc/acc_task_fetcher.md
# acc_task_fetcher

Consumer end of the accelerator ready queue. Pops one complete task slot (task id, task wid, NARGS arguments; 64-bit words) through a QueueRead master port and assembles it into a parallel task descriptor. Presents the descriptor to the accelerator core over a valid/ready handshake. Sits between the ready queue and the accelerator's task-start logic.

## Interface
- NARGS, 1: arguments per task; must be ≥ 1.
- SLOT_SIZE (derived, not overridable): NARGS+2 words per slot.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- read_port  QueueRead.master  —  read (out, 1), empty (in, 1), dout (in, 64). dout is registered by the queue one cycle after read.
- task_valid  out  1  descriptor valid.
- task_ready  in  1  accelerator accepts the descriptor.
- task_id  out  64  slot word 0.
- task_wid  out  64  slot word 1.
- task_args  out  64*NARGS  slot word 2+i at bits [64*i +: 64].
- tasks_dispatched  out  32  count of accepted descriptors; wraps modulo 2^32.

## Operation
- Queue contract: empty=0 guarantees at least SLOT_SIZE words are present. Once a slot is started, it is read in full without re-checking empty.
- FSM states: IDLE, READ, LAST, VALID.
  - IDLE: if empty=0, go to READ and clear rd_cnt and cap_cnt.
  - READ: read=1 every cycle. rd_cnt increments. When rd_cnt==SLOT_SIZE-1, go to LAST.
  - LAST: read=0. Capture the final word, then go to VALID.
  - VALID: task_valid=1. On task_ready=1, go to IDLE and increment tasks_dispatched.
- Capture: in every cycle after a read cycle (READ after its first cycle, and LAST), dout is written into payload word cap_cnt, and cap_cnt increments.
  - Word 0 → task_id, word 1 → task_wid, word k≥2 → task_args slot k-2.
- read is decoded combinationally from the state register only (state==READ). It never depends on empty or task_ready.
- Payload registers hold their value in VALID and IDLE. They change only during capture.
- Exactly SLOT_SIZE reads are issued per task. The bench flags a read when not in READ as an error.
- Counters: rd_cnt and cap_cnt are $clog2(SLOT_SIZE+1) bits wide. tasks_dispatched is 32-bit unsigned.
- Reset values: state=IDLE, read=0, task_valid=0, task_id=0, task_wid=0, task_args=0, tasks_dispatched=0, counters=0.
- Reset mid-operation (READ or LAST): return to IDLE and drop the partial slot. The queue shares rst, so no words are orphaned.

## Timing
- Let cycle c be an IDLE cycle with empty=0.
  - read=1 in cycles c+1 … c+SLOT_SIZE.
  - LAST in cycle c+SLOT_SIZE+1.
  - task_valid=1 from cycle c+SLOT_SIZE+2.
- Start-to-valid latency is SLOT_SIZE+2 cycles.
- Handshake: transfer occurs on the edge where task_valid and task_ready are both 1. task_valid drops the next cycle (IDLE). Payload is stable while task_valid=1.
- Throughput: one slot every SLOT_SIZE+3 cycles with task_ready tied high and the queue never empty. IDLE always costs one cycle. No overlap of fetch with VALID.
- task_ready asserted while task_valid=0 is ignored.
- empty changing during READ or LAST is ignored.

## Structure
- Shared package acc_pkg: WORD_W=64, the state enum (IDLE, READ, LAST, VALID), and the slot word-order constants SLOT_TID_IDX=0, SLOT_TWID_IDX=1, SLOT_ARG0_IDX=2.
- The same package is used by the queue's writer side.
- No sub-module: a single module with the FSM, two counters, and the payload register array.

## Test plan
- NARGS=2; queue preloaded with words 0x11, 0x22, 0xA0, 0xA1; task_ready=1 → read high for exactly 4 cycles. task_id=0x11, task_wid=0x22, task_args={0xA1,0xA0}. task_valid for 1 cycle. tasks_dispatched=1.
- Two slots back-to-back, task_ready=1 → second task_valid arrives 7 cycles after the first. Payloads are correct in order. tasks_dispatched=2.
- task_ready=0 for 20 cycles with a second slot queued → task_valid stays 1, payload unchanged, read=0 throughout. On task_ready=1, the next fetch starts one cycle after IDLE.
- empty=1 for 50 cycles → read never asserts and task_valid=0. empty drops at cycle c → first read at c+1.
- rst asserted during the third READ cycle → next cycle all outputs are at reset values. A fresh slot afterwards is fetched correctly.
- Force tasks_dispatched to 0xFFFF_FFFF, then complete one handshake → tasks_dispatched=0.
